network_sequencer: RTL

//   Control FSM for the 4-input/4-neuron layer datapath. Sits directly upstream of the

---
 rtl/network_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/network_sequencer.sv
// Control FSM for the 4-input/4-neuron layer datapath: loads samples, sequences layers, flags results.
// Optional feature: define NETSEQ_FRAME_CNT_EN to add the saturating frame_count output.
module network_sequencer #(
  parameter int unsigned NUM_LAYERS     = 3,
  parameter int unsigned COMPUTE_CYCLES = 4,
  parameter int unsigned LAYER_W        = 2,
  parameter int unsigned CNT_W          = 3
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [1:0]         selector,
  output logic               neuron_en,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               out_valid,
  output logic               busy
`ifdef NETSEQ_FRAME_CNT_EN
  ,
  output logic [15:0]        frame_count
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, WRITEBACK} state_t;

  localparam logic [1:0]         SEL_SHIFT  = 2'b00;
  localparam logic [1:0]         SEL_HOLD   = 2'b01;
  localparam logic [1:0]         SEL_LOAD   = 2'b10;
  localparam logic [CNT_W-1:0]   COMP_LAST  = CNT_W'(COMPUTE_CYCLES - 1);
  localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(NUM_LAYERS - 1);

  state_t             state_q, state_d;
  logic [1:0]         load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0]   comp_cnt_q, comp_cnt_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic               pending_q, pending_d;
  logic               accept;
  logic               frame_done;

  // State and counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      load_cnt_q <= 2'd0;
      comp_cnt_q <= '0;
      layer_q    <= '0;
      pending_q  <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      comp_cnt_q <= comp_cnt_d;
      layer_q    <= layer_d;
      pending_q  <= pending_d;
      // Each accept during a pending frame shifts one previous result onto network_outputs
      out_valid  <= accept && pending_q;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    comp_cnt_d = comp_cnt_q;
    layer_d    = layer_q;
    pending_d  = pending_q;
    in_ready   = 1'b0;
    selector   = SEL_HOLD;
    neuron_en  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          selector = SEL_SHIFT;
          if (load_cnt_q == 2'd3) begin
            load_cnt_d = 2'd0;
            pending_d  = 1'b0;
            state_d    = COMPUTE;
          end else begin
            load_cnt_d = load_cnt_q + 2'd1;
          end
        end
      end
      COMPUTE: begin
        neuron_en = 1'b1;
        busy      = 1'b1;
        if (comp_cnt_q == COMP_LAST) begin
          comp_cnt_d = '0;
          state_d    = WRITEBACK;
        end else begin
          comp_cnt_d = comp_cnt_q + CNT_W'(1);
        end
      end
      WRITEBACK: begin
        selector = SEL_LOAD;
        busy     = 1'b1;
        if (layer_q != LAYER_LAST) begin
          layer_d = layer_q + LAYER_W'(1);
          state_d = COMPUTE;
        end else begin
          layer_d    = '0;
          pending_d  = 1'b1;
          frame_done = 1'b1;
          state_d    = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign layer_idx = layer_q;

`ifdef NETSEQ_FRAME_CNT_EN
  // Saturating count of completed frames
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_count <= 16'd0;
    end else if (frame_done && (frame_count != 16'hFFFF)) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`else
  logic unused_frame_done;
  assign unused_frame_done = frame_done;
`endif

endmodule
